// File: rtl/div_unit_if.sv
// Request/response bundle for the 32-bit divider.
//   master : the requester (drives start, signed_op, dividend, divisor)
//   slave  : the divider   (drives busy, done, div_zero, quotient,
//            remainder and the DivCounter debug count)
interface div_unit_if;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic [5:0]  DivCounter;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, div_zero, quotient, remainder, DivCounter
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, div_zero, quotient, remainder, DivCounter
  );
endinterface

// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider (DIV / DIVU), one quotient bit per cycle.
// Ports:
//   Clk    - rising-edge clock
//   reset  - synchronous, active-high; returns to IDLE and clears all state
//   bus    - div_unit_if.slave:
//              start/signed_op/dividend/divisor : request, sampled in IDLE only
//              busy      : high in every state except IDLE
//              done      : one-cycle pulse in DONE
//              div_zero  : last completed operation had a zero divisor
//              quotient  : LO result, held until the next result
//              remainder : HI result, held until the next result
//              DivCounter: iteration count (debug)
// Signed operation divides magnitudes and fixes signs afterwards: the
// quotient is negated when operand signs differ, the remainder takes the
// sign of the dividend (truncating division).
module div_unit (
  input  logic       Clk,
  input  logic       reset,
  div_unit_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ITER = 3'd1,
    FIX  = 3'd2,
    DONE = 3'd3,
    ZERO = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        busy_c, done_c;

  logic        dvd_neg_q;
  logic        dvs_neg_q;
  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] dvs_q;
  logic [5:0]  cnt_q;
  logic [31:0] quotient_q;
  logic [31:0] remainder_q;
  logic        div_zero_q;

  logic [32:0] rem_sh;
  logic [32:0] trial;
  logic        trial_ok;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // Magnitude of a two's-complement word; 0x80000000 maps to itself,
  // which is the correct unsigned magnitude 2^31.
  function automatic logic [31:0] abs32(input logic signed [31:0] v);
    return v[31] ? neg32(v) : v;
  endfunction

  // Restoring step: the bit shifted out of the remainder can make the
  // shifted value reach 2^32, so a set bit 32 means the trial is
  // non-negative regardless of the wrapped difference.
  assign rem_sh   = {rem_q, quo_q[31]};
  assign trial    = rem_sh - {1'b0, dvs_q};
  assign trial_ok = rem_sh[32] | ~trial[32];

  always_ff @(posedge Clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy_c  = 1'b1;
    done_c  = 1'b0;
    case (state_q)
      IDLE: begin
        busy_c = 1'b0;
        if (bus.start) state_d = (bus.divisor == 32'd0) ? ZERO : ITER;
      end
      // The counter reaches 32 on the edge that leaves ITER.
      ITER:    if (cnt_q == 6'd31) state_d = FIX;
      FIX:     state_d = DONE;
      ZERO:    state_d = DONE;
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      dvd_neg_q   <= 1'b0;
      dvs_neg_q   <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            // Sign flags are pre-gated with signed_op so FIX needs no mode test.
            dvd_neg_q <= bus.signed_op & bus.dividend[31];
            dvs_neg_q <= bus.signed_op & bus.divisor[31];
            rem_q     <= '0;
            cnt_q     <= '0;
            if (bus.divisor == 32'd0) begin
              // ZERO returns the dividend exactly as presented.
              quo_q <= bus.dividend;
              dvs_q <= '0;
            end else if (bus.signed_op) begin
              quo_q <= abs32(bus.dividend);
              dvs_q <= abs32(bus.divisor);
            end else begin
              quo_q <= bus.dividend;
              dvs_q <= bus.divisor;
            end
          end
        end
        ITER: begin
          rem_q <= trial_ok ? trial[31:0] : rem_sh[31:0];
          quo_q <= {quo_q[30:0], trial_ok};
          cnt_q <= cnt_q + 6'd1;
        end
        FIX: begin
          quotient_q  <= (dvd_neg_q ^ dvs_neg_q) ? neg32(quo_q) : quo_q;
          remainder_q <= dvd_neg_q ? neg32(rem_q) : rem_q;
          div_zero_q  <= 1'b0;
        end
        ZERO: begin
          quotient_q  <= 32'hFFFF_FFFF;
          remainder_q <= quo_q;
          div_zero_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.div_zero   = div_zero_q;
  assign bus.quotient   = quotient_q;
  assign bus.remainder  = remainder_q;
  assign bus.DivCounter = cnt_q;

endmodule
